// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for mem_port_arbiter.
//   - arb_state_e : arbiter FSM state encoding (3 bits)
//   - grant_t     : which requester was served last
//   - GRANT_FETCH / GRANT_DATA : grant_t values
package mem_arb_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle = 3'd0,
        StFPc  = 3'd1,
        StFPf  = 3'd2,
        StFEnd = 3'd3,
        StDAcc = 3'd4,
        StDEnd = 3'd5
    } arb_state_e;

    typedef logic grant_t;

    localparam grant_t GRANT_FETCH = 1'b0;
    localparam grant_t GRANT_DATA  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the three buses around the memory arbiter.
//   Fetch side : i_mem_pc, i_mem_prefetch in; i_mem_opcode, i_mem_prefetch_opcode, i_mem_rdy out
//   Data side  : d_req, d_we, d_addr, d_wdata in; d_rdata, d_ack out
//   Memory side: mem_addr, mem_we, mem_wdata out; mem_rdata in (one cycle after address)
// Modport slave is the arbiter's view; master is the surrounding system's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);

    logic [ADDR_W-1:0] i_mem_pc;
    logic [ADDR_W-1:0] i_mem_prefetch;
    logic [DATA_W-1:0] i_mem_opcode;
    logic [DATA_W-1:0] i_mem_prefetch_opcode;
    logic              i_mem_rdy;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_mem_pc, i_mem_prefetch,
        output i_mem_opcode, i_mem_prefetch_opcode, i_mem_rdy,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output i_mem_pc, i_mem_prefetch,
        input  i_mem_opcode, i_mem_prefetch_opcode, i_mem_rdy,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between the instruction
// fetch (opcode at pc plus prefetch word) and the data load/store port.
// Ports:
//   clk   - clock
//   a_rst - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.slave: fetch, data and memory buses
// The last fetched opcode pair is held with its address tags so i_mem_rdy stays high
// without touching memory while pc/prefetch are unchanged. Fetch and data contend in
// IDLE; on a tie the requester not served last wins.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input logic               clk,
    input logic               a_rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] pc_tag_q, pc_tag_d;
    logic [ADDR_W-1:0] pf_tag_q, pf_tag_d;
    logic [DATA_W-1:0] opcode_q, opcode_d;
    logic [DATA_W-1:0] pf_opcode_q, pf_opcode_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    grant_t            last_grant_q, last_grant_d;
    logic              is_load_q, is_load_d;

    logic              tags_match;
    logic              fetch_need;
    logic [ADDR_W-1:0] mem_addr_c;
    logic              mem_we_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              d_ack_c;
    logic [DATA_W-1:0] d_rdata_c;

    assign tags_match = (bus.i_mem_pc == pc_tag_q) && (bus.i_mem_prefetch == pf_tag_q);
    assign fetch_need = ~(valid_q & tags_match);

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_q      <= StIdle;
            valid_q      <= 1'b0;
            pc_tag_q     <= '0;
            pf_tag_q     <= '0;
            opcode_q     <= '0;
            pf_opcode_q  <= '0;
            rdata_q      <= '0;
            last_grant_q <= GRANT_FETCH;
            is_load_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            pc_tag_q     <= pc_tag_d;
            pf_tag_q     <= pf_tag_d;
            opcode_q     <= opcode_d;
            pf_opcode_q  <= pf_opcode_d;
            rdata_q      <= rdata_d;
            last_grant_q <= last_grant_d;
            is_load_q    <= is_load_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        pc_tag_d     = pc_tag_q;
        pf_tag_d     = pf_tag_q;
        opcode_d     = opcode_q;
        pf_opcode_d  = pf_opcode_q;
        rdata_d      = rdata_q;
        last_grant_d = last_grant_q;
        is_load_d    = is_load_q;
        mem_addr_c   = '0;
        mem_we_c     = 1'b0;
        mem_wdata_c  = '0;
        d_ack_c      = 1'b0;
        d_rdata_c    = rdata_q;

        case (state_q)
            StIdle: begin
                if (bus.d_req && fetch_need) begin
                    state_d = (last_grant_q == GRANT_FETCH) ? StDAcc : StFPc;
                end else if (bus.d_req) begin
                    state_d = StDAcc;
                end else if (fetch_need) begin
                    state_d = StFPc;
                end
            end
            StFPc: begin
                mem_addr_c = bus.i_mem_pc;
                pc_tag_d   = bus.i_mem_pc;
                valid_d    = 1'b0;
                state_d    = StFPf;
            end
            StFPf: begin
                // mem_rdata now carries the word addressed in StFPc.
                mem_addr_c = bus.i_mem_prefetch;
                pf_tag_d   = bus.i_mem_prefetch;
                opcode_d   = bus.mem_rdata;
                state_d    = StFEnd;
            end
            StFEnd: begin
                // Tags may already be stale after a branch; the tag compare catches it.
                pf_opcode_d  = bus.mem_rdata;
                valid_d      = 1'b1;
                last_grant_d = GRANT_FETCH;
                state_d      = StIdle;
            end
            StDAcc: begin
                mem_addr_c  = bus.d_addr;
                mem_we_c    = bus.d_we;
                mem_wdata_c = bus.d_wdata;
                is_load_d   = ~bus.d_we;
                // A store over a held opcode invalidates it (self-modifying code).
                if (bus.d_we && ((bus.d_addr == pc_tag_q) || (bus.d_addr == pf_tag_q))) begin
                    valid_d = 1'b0;
                end
                state_d = StDEnd;
            end
            StDEnd: begin
                d_ack_c = 1'b1;
                // Forward the load word so d_rdata is already valid in the ack cycle.
                if (is_load_q) begin
                    rdata_d   = bus.mem_rdata;
                    d_rdata_c = bus.mem_rdata;
                end
                last_grant_d = GRANT_DATA;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.i_mem_opcode          = opcode_q;
    assign bus.i_mem_prefetch_opcode = pf_opcode_q;
    assign bus.i_mem_rdy             = valid_q & tags_match & (state_q == StIdle);
    assign bus.d_rdata               = d_rdata_c;
    assign bus.d_ack                 = d_ack_c;
    assign bus.mem_addr              = mem_addr_c;
    assign bus.mem_we                = mem_we_c;
    assign bus.mem_wdata             = mem_wdata_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter with a
// one-cycle-latency memory model. Outputs are sampled 2 time units after posedge.
module tb_mem_port_arbiter;

    logic clk;
    logic a_rst;

    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [15:0] poke_data;
    logic [15:0] mem [1024];

    int tests_run;
    int tests_failed;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .a_rst (a_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous single-port memory: read data appears the cycle after the address.
    always_ff @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr[9:0]];
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic poke(input logic [9:0] addr, input logic [15:0] data);
        poke_en   = 1'b1;
        poke_addr = addr;
        poke_data = data;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic test_reset();
        a_rst              = 1'b0;
        bus.i_mem_pc       = 16'h0000;
        bus.i_mem_prefetch = 16'h0000;
        bus.d_req          = 1'b0;
        bus.d_we           = 1'b0;
        bus.d_addr         = 16'h0000;
        bus.d_wdata        = 16'h0000;
        poke(10'h010, 16'hA5A5);
        poke(10'h011, 16'h1234);
        poke(10'h200, 16'hBEEF);
        poke(10'h040, 16'hC0DE);
        poke(10'h300, 16'h1111);
        tests_run++;
        if (bus.i_mem_rdy !== 1'b0 || bus.d_ack !== 1'b0 || bus.mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: rdy=%b ack=%b we=%b, required 0 0 0",
                     bus.i_mem_rdy, bus.d_ack, bus.mem_we);
        end
        tests_run++;
        if (bus.i_mem_opcode !== 16'h0 || bus.i_mem_prefetch_opcode !== 16'h0 ||
            bus.d_rdata !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_data: op=%h pfop=%h rdata=%h, required 0 0 0",
                     bus.i_mem_opcode, bus.i_mem_prefetch_opcode, bus.d_rdata);
        end
        tests_run++;
        if (bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_mem: addr=%h wdata=%h, required 0 0", bus.mem_addr, bus.mem_wdata);
        end
    endtask

    task automatic test_fetch();
        bus.i_mem_pc       = 16'h0010;
        bus.i_mem_prefetch = 16'h0011;
        a_rst              = 1'b1;
        tick();
        tests_run++;
        if (bus.mem_addr !== 16'h0010) begin
            tests_failed++;
            $display("FAIL fetch_pc_addr: got %h, required 0010", bus.mem_addr);
        end
        tick();
        tests_run++;
        if (bus.mem_addr !== 16'h0011 || bus.i_mem_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_pf_addr: addr=%h rdy=%b, required 0011 0", bus.mem_addr,
                     bus.i_mem_rdy);
        end
        tick();
        tests_run++;
        if (bus.i_mem_opcode !== 16'hA5A5 || bus.i_mem_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_end: op=%h rdy=%b, required a5a5 0", bus.i_mem_opcode,
                     bus.i_mem_rdy);
        end
        tick();
        tests_run++;
        if (bus.i_mem_rdy !== 1'b1 || bus.i_mem_opcode !== 16'hA5A5 ||
            bus.i_mem_prefetch_opcode !== 16'h1234) begin
            tests_failed++;
            $display("FAIL fetch_ready: rdy=%b op=%h pfop=%h, required 1 a5a5 1234",
                     bus.i_mem_rdy, bus.i_mem_opcode, bus.i_mem_prefetch_opcode);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (bus.i_mem_rdy !== 1'b1 || bus.mem_addr !== 16'h0) begin
                tests_failed++;
                $display("FAIL fetch_hold[%0d]: rdy=%b addr=%h, required 1 0000", i,
                         bus.i_mem_rdy, bus.mem_addr);
            end
        end
    endtask

    task automatic test_collision();
        a_rst      = 1'b0;
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0200;
        tick();
        a_rst = 1'b1;
        tick();
        tests_run++;
        if (bus.mem_addr !== 16'h0200 || bus.mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL coll_data_first: addr=%h we=%b, required 0200 0", bus.mem_addr,
                     bus.mem_we);
        end
        tick();
        tests_run++;
        if (bus.d_ack !== 1'b1 || bus.d_rdata !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL coll_ack: ack=%b rdata=%h, required 1 beef", bus.d_ack, bus.d_rdata);
        end
        // d_req stays high: renewed request collides with the pending fetch.
        tick();
        tests_run++;
        if (bus.d_ack !== 1'b0 || bus.d_rdata !== 16'hBEEF) begin
            tests_failed++;
            $display("FAIL coll_ack_pulse: ack=%b rdata=%h, required 0 beef", bus.d_ack,
                     bus.d_rdata);
        end
        tick();
        tests_run++;
        if (bus.mem_addr !== 16'h0010) begin
            tests_failed++;
            $display("FAIL coll_fetch_second: addr=%h, required 0010", bus.mem_addr);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.i_mem_rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL coll_fetch_done: rdy=%b, required 1", bus.i_mem_rdy);
        end
        tick();
        tests_run++;
        if (bus.mem_addr !== 16'h0200) begin
            tests_failed++;
            $display("FAIL coll_data_again: addr=%h, required 0200", bus.mem_addr);
        end
        tick();
        tests_run++;
        if (bus.d_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL coll_ack2: ack=%b, required 1", bus.d_ack);
        end
        bus.d_req = 1'b0;
        tick();
    endtask

    task automatic test_self_modify();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0010;
        bus.d_wdata = 16'h5555;
        tick();
        tests_run++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0010 || bus.mem_wdata !== 16'h5555) begin
            tests_failed++;
            $display("FAIL smc_store: we=%b addr=%h wdata=%h, required 1 0010 5555",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tick();
        tests_run++;
        if (bus.d_ack !== 1'b1 || bus.mem_we !== 1'b0) begin
            tests_failed++;
            $display("FAIL smc_ack: ack=%b we=%b, required 1 0", bus.d_ack, bus.mem_we);
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        tick();
        tests_run++;
        if (bus.i_mem_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL smc_invalidate: rdy=%b, required 0", bus.i_mem_rdy);
        end
        tick();
        tests_run++;
        if (bus.mem_addr !== 16'h0010) begin
            tests_failed++;
            $display("FAIL smc_refetch: addr=%h, required 0010", bus.mem_addr);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.i_mem_rdy !== 1'b1 || bus.i_mem_opcode !== 16'h5555) begin
            tests_failed++;
            $display("FAIL smc_new_opcode: rdy=%b op=%h, required 1 5555", bus.i_mem_rdy,
                     bus.i_mem_opcode);
        end
    endtask

    task automatic test_branch();
        a_rst              = 1'b0;
        bus.i_mem_pc       = 16'h0010;
        bus.i_mem_prefetch = 16'h0011;
        tick();
        a_rst = 1'b1;
        tick();
        tick();
        bus.i_mem_pc = 16'h0040;
        tick();
        tests_run++;
        if (bus.i_mem_opcode !== 16'h5555 || bus.i_mem_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_stale_op: op=%h rdy=%b, required 5555 0", bus.i_mem_opcode,
                     bus.i_mem_rdy);
        end
        tick();
        tests_run++;
        if (bus.i_mem_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL branch_not_ready: rdy=%b, required 0", bus.i_mem_rdy);
        end
        tick();
        tests_run++;
        if (bus.mem_addr !== 16'h0040) begin
            tests_failed++;
            $display("FAIL branch_refetch: addr=%h, required 0040", bus.mem_addr);
        end
        tick();
        tick();
        tick();
        tests_run++;
        if (bus.i_mem_rdy !== 1'b1 || bus.i_mem_opcode !== 16'hC0DE ||
            bus.i_mem_prefetch_opcode !== 16'h1234) begin
            tests_failed++;
            $display("FAIL branch_ready: rdy=%b op=%h pfop=%h, required 1 c0de 1234",
                     bus.i_mem_rdy, bus.i_mem_opcode, bus.i_mem_prefetch_opcode);
        end
    endtask

    task automatic test_reset_mid_store();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 16'h0300;
        bus.d_wdata = 16'h9999;
        tick();
        tests_run++;
        if (bus.mem_we !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_store_start: we=%b, required 1", bus.mem_we);
        end
        a_rst = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0 || bus.mem_wdata !== 16'h0) begin
            tests_failed++;
            $display("FAIL rst_store_abort: we=%b addr=%h wdata=%h, required 0 0000 0000",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        tests_run++;
        if (bus.i_mem_opcode !== 16'h0 || bus.i_mem_prefetch_opcode !== 16'h0 ||
            bus.d_rdata !== 16'h0 || bus.i_mem_rdy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_store_outputs: op=%h pfop=%h rdata=%h rdy=%b, required 0 0 0 0",
                     bus.i_mem_opcode, bus.i_mem_prefetch_opcode, bus.d_rdata, bus.i_mem_rdy);
        end
        bus.d_req = 1'b0;
        bus.d_we  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (bus.d_ack !== 1'b0) begin
                tests_failed++;
                $display("FAIL rst_store_no_ack[%0d]: ack=%b, required 0", i, bus.d_ack);
            end
        end
        tests_run++;
        if (mem[10'h300] !== 16'h1111) begin
            tests_failed++;
            $display("FAIL rst_store_no_commit: mem=%h, required 1111", mem[10'h300]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ack_seen;
        bit         ready;
        bus.i_mem_pc       = 16'h0010;
        bus.i_mem_prefetch = 16'h0011;
        a_rst              = 1'b1;
        ready              = 1'b0;
        for (int i = 0; i < 10 && !ready; i++) begin
            tick();
            ready = (bus.i_mem_rdy === 1'b1);
        end
        tests_run++;
        if (!ready) begin
            tests_failed++;
            $display("FAIL b2b_fetch_timeout: rdy=%b, required 1 within 10 cycles", bus.i_mem_rdy);
        end
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 16'h0200;
        ack_seen   = 8'h00;
        for (int i = 1; i < 8; i++) begin
            tick();
            ack_seen[i] = bus.d_ack;
            tests_run++;
            if (bus.mem_we !== 1'b0) begin
                tests_failed++;
                $display("FAIL b2b_no_write[%0d]: we=%b, required 0", i, bus.mem_we);
            end
            if (bus.d_ack === 1'b1) begin
                tests_run++;
                if (bus.d_rdata !== 16'hBEEF) begin
                    tests_failed++;
                    $display("FAIL b2b_rdata[%0d]: got %h, required beef", i, bus.d_rdata);
                end
            end
            if (i == 5) bus.d_req = 1'b0;
        end
        tests_run++;
        if (ack_seen !== 8'b0010_0100) begin
            tests_failed++;
            $display("FAIL b2b_ack_timing: ack cycles=%b, required 00100100", ack_seen);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        poke_en      = 1'b0;
        poke_addr    = 10'h0;
        poke_data    = 16'h0;
        a_rst        = 1'b0;
        test_reset();
        test_fetch();
        test_collision();
        test_self_modify();
        test_branch();
        test_reset_mid_store();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
